// File: rtl/load_issue_unit.sv
// ---------------------------------------------------------------------------
// load_issue_unit
//
// Picks the oldest load-queue entry that is ready to fire (valid, address
// known, not executed, not sleeping) and presents it to the data-memory
// request port through a valid/ready handshake. When memory accepts, the
// unit reports load_fired/load_fired_index so the load queue and searcher
// update executed/sleep/forward state on that same edge.
//
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   ldq_valid/address/rob_tag  per-entry state in physical order
//   ldq_rotated_*              per-entry flags rotated so the head is bit 0
//   head                       load queue head pointer
//   flush                      abandon any pending request
//   mem_req_valid/ready        request handshake towards memory
//   mem_req_address/rob_tag    payload of the pending request
//   load_fired                 request accepted this cycle
//   load_fired_index           physical index of the pending/fired load
//   busy                       a request is pending (REQ state)
// ---------------------------------------------------------------------------
module load_issue_unit #(
    parameter int XLEN          = 32,
    parameter int ROB_TAG_WIDTH = 32,
    parameter int LDQ_SIZE      = 32
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [LDQ_SIZE-1:0]                    ldq_valid,
    input  logic [LDQ_SIZE-1:0][XLEN-1:0]          ldq_address,
    input  logic [LDQ_SIZE-1:0][ROB_TAG_WIDTH-1:0] ldq_rob_tag,
    input  logic [LDQ_SIZE-1:0]                    ldq_rotated_valid,
    input  logic [LDQ_SIZE-1:0]                    ldq_rotated_address_valid,
    input  logic [LDQ_SIZE-1:0]                    ldq_rotated_sleeping,
    input  logic [LDQ_SIZE-1:0]                    ldq_rotated_executed,
    input  logic [$clog2(LDQ_SIZE)-1:0]            head,
    input  logic                                   flush,
    output logic                                   mem_req_valid,
    input  logic                                   mem_req_ready,
    output logic [XLEN-1:0]                        mem_req_address,
    output logic [ROB_TAG_WIDTH-1:0]               mem_req_rob_tag,
    output logic                                   load_fired,
    output logic [$clog2(LDQ_SIZE)-1:0]            load_fired_index,
    output logic                                   busy
);

    localparam int IDX_W = $clog2(LDQ_SIZE);
    localparam logic [LDQ_SIZE-1:0] ONE_HOT0 = {{(LDQ_SIZE-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [XLEN-1:0]          addr_q,  addr_d;
    logic [ROB_TAG_WIDTH-1:0] tag_q,   tag_d;
    logic [IDX_W-1:0]         idx_q,   idx_d;

    logic                     in_req_s;
    logic                     abort_s;
    logic                     req_valid_s;
    logic                     handshake_s;
    logic [IDX_W-1:0]         excl_rel_s;
    logic [LDQ_SIZE-1:0]      excl_s;
    logic [LDQ_SIZE-1:0]      elig_s;
    logic                     any_elig_s;
    logic [IDX_W-1:0]         sel_rel_s;
    logic [IDX_W-1:0]         sel_phys_s;

    // Request status: pending, aborted (flush wins over ready), accepted.
    always_comb begin
        in_req_s    = (state_q == ST_REQ);
        abort_s     = in_req_s & (flush | ~ldq_valid[idx_q]);
        req_valid_s = in_req_s & ~abort_s;
        handshake_s = req_valid_s & mem_req_ready;
    end

    // Eligibility in age order. The pending entry is masked out so that on a
    // handshake the next-oldest load can be captured before the load queue
    // has marked the current one executed.
    always_comb begin
        excl_rel_s = idx_q - head;
        if (in_req_s) begin
            excl_s = ONE_HOT0 << excl_rel_s;
        end else begin
            excl_s = '0;
        end
        elig_s = ldq_rotated_valid & ldq_rotated_address_valid &
                 ~ldq_rotated_sleeping & ~ldq_rotated_executed & ~excl_s;
        any_elig_s = |elig_s;
    end

    // Oldest eligible entry: lowest rotated bit, mapped back to a physical
    // index by adding head (wraps naturally in IDX_W bits).
    always_comb begin
        sel_rel_s = '0;
        for (int i = LDQ_SIZE - 1; i >= 0; i--) begin
            sel_rel_s = elig_s[i] ? IDX_W'(i) : sel_rel_s;
        end
        sel_phys_s = head + sel_rel_s;
    end

    // Next-state logic for the IDLE/REQ controller and captured request.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tag_d   = tag_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (~flush & any_elig_s) begin
                    state_d = ST_REQ;
                    idx_d   = sel_phys_s;
                    addr_d  = ldq_address[sel_phys_s];
                    tag_d   = ldq_rob_tag[sel_phys_s];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (abort_s) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    addr_d  = '0;
                    tag_d   = '0;
                end else if (handshake_s) begin
                    if (any_elig_s) begin
                        // Back-to-back issue: stay in REQ with the next load.
                        state_d = ST_REQ;
                        idx_d   = sel_phys_s;
                        addr_d  = ldq_address[sel_phys_s];
                        tag_d   = ldq_rob_tag[sel_phys_s];
                    end else begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        addr_d  = '0;
                        tag_d   = '0;
                    end
                end else begin
                    // Backpressure: hold the captured request unchanged.
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                addr_d  = '0;
                tag_d   = '0;
            end
        endcase
    end

    // State and captured-request registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            tag_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tag_q   <= tag_d;
            idx_q   <= idx_d;
        end
    end

    assign mem_req_valid    = req_valid_s;
    assign mem_req_address  = addr_q;
    assign mem_req_rob_tag  = tag_q;
    assign load_fired       = handshake_s;
    assign load_fired_index = in_req_s ? idx_q : '0;
    assign busy             = in_req_s;

endmodule
